// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter that lets one of four sprite engines at a time drive the
// VGA adapter's pixel write port, with a watchdog that revokes a stuck grant.
module vga_write_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [3:0]  plot_in,
    input  logic [35:0] x_in,
    input  logic [31:0] y_in,
    input  logic [11:0] colour_in,
    output logic [3:0]  gnt,
    output logic [8:0]  x_out,
    output logic [7:0]  y_out,
    output logic [2:0]  colour_out,
    output logic        plot,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        err_q, err_d;

    logic [1:0]  sel;
    logic [1:0]  cand;
    logic        found;

    // Search starts just after the previous owner so nobody can be starved.
    always_comb begin
        sel   = last_q + 2'd1;
        cand  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (found) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << sel;
                    owner_d = sel;
                    cnt_d   = 16'd0;
                end
            end
            OWN: begin
                // done wins over the watchdog when both land on the same edge
                if (done[owner_q] || cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    gnt_d   = 4'b0000;
                    last_d  = owner_q;
                    if (!done[owner_q]) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 16'd1;
                    x_d      = x_in[9*owner_q +: 9];
                    y_d      = y_in[8*owner_q +: 8];
                    colour_d = colour_in[3*owner_q +: 3];
                    plot_d   = plot_in[owner_q];
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= 16'd0;
            x_q      <= 9'd0;
            y_q      <= 8'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            err_q    <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign colour_out  = colour_q;
    assign plot        = plot_q;
    assign busy        = |gnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_vga_write_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, done, plot_in;
    logic [35:0] x_in;
    logic [31:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  gnt;
    logic [8:0]  x_out;
    logic [7:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port, how long they have had it, and
    // whether the one-cycle cooldown after a release is still pending.
    int         m_owner;
    int         m_last;
    int         m_cycles;
    bit         m_cool;
    bit         m_err;
    logic [8:0] m_x;
    logic [7:0] m_y;
    logic [2:0] m_c;
    bit         m_plot;

    always #5 clk = ~clk;

    vga_write_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .plot_in     (plot_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .gnt         (gnt),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour_out  (colour_out),
        .plot        (plot),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        if (!reset) begin
            m_owner = -1; m_last = 3; m_cycles = 0; m_cool = 0; m_err = 0;
            m_x = 0; m_y = 0; m_c = 0; m_plot = 0;
        end else if (m_owner >= 0) begin
            if (done[m_owner] || m_cycles == TO - 1) begin
                if (!done[m_owner]) m_err = 1;
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1;
                m_plot  = 0;
            end else begin
                m_cycles++;
                m_x    = x_in[9*m_owner +: 9];
                m_y    = y_in[8*m_owner +: 8];
                m_c    = colour_in[3*m_owner +: 3];
                m_plot = plot_in[m_owner];
            end
        end else if (m_cool) begin
            m_cool = 0;
            m_plot = 0;
        end else begin
            m_plot = 0;
            for (int k = 1; k <= 4; k++) begin
                if (req[(m_last + k) % 4]) begin
                    m_owner  = (m_last + k) % 4;
                    m_cycles = 0;
                    break;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        checkVal("gnt", gnt, exp_gnt);
        checkVal("busy", busy, (m_owner >= 0));
        checkVal("plot", plot, m_plot);
        checkVal("x_out", x_out, m_x);
        checkVal("y_out", y_out, m_y);
        checkVal("colour_out", colour_out, m_c);
        checkVal("timeout_err", timeout_err, m_err);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
    endtask

    initial begin
        int w;
        int own;
        int idx;
        reset = 1'b0; req = 0; done = 0; plot_in = 0;
        x_in = 0; y_in = 0; colour_in = 0;
        m_owner = -1; m_last = 3; m_cycles = 0; m_cool = 0; m_err = 0;
        m_x = 0; m_y = 0; m_c = 0; m_plot = 0;

        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        applyStimulus();

        // single requester
        req = 4'b0010;
        applyStimulus();
        checkVal("single_gnt", gnt, 4'b0010);
        x_in = 36'd100 << 9;
        plot_in = 4'b0010;
        applyStimulus();
        checkVal("single_x", x_out, 9'd100);
        checkVal("single_plot", plot, 1'b1);
        done = 4'b0010; req = 4'b0000;
        applyStimulus();
        checkVal("single_release_gnt", gnt, 4'b0000);
        done = 4'b0000;
        applyStimulus();
        checkVal("single_release_cycle", gnt, 4'b0000);
        applyStimulus();

        // round-robin with everyone requesting
        doReset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (gnt == 4'b0000 && w < 8) begin
                applyStimulus();
                w++;
            end
            checkVal("rr_wait_bound", (w < 8), 1);
            idx = 7;
            for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
            checkVal("rr_order", idx, g % 4);
            applyStimulus();
            applyStimulus();
            done = 4'(1 << (g % 4));
            applyStimulus();
            done = 4'b0000;
        end

        // watchdog revokes a grant that never finishes
        doReset();
        req = 4'b0100;
        applyStimulus();
        checkVal("to_gnt", gnt, 4'b0100);
        own = 1;
        while (gnt[2] && own < 20) begin
            applyStimulus();
            if (gnt[2]) own++;
        end
        checkVal("to_own_cycles", own, TO);
        checkVal("to_err", timeout_err, 1'b1);
        req = 4'b1000;
        w = 0;
        while (gnt == 4'b0000 && w < 8) begin
            applyStimulus();
            w++;
        end
        checkVal("to_next_gnt", gnt, 4'b1000);
        checkVal("to_err_sticky", timeout_err, 1'b1);

        // done on the last allowed cycle beats the watchdog
        doReset();
        req = 4'b0001;
        applyStimulus();
        repeat (TO - 1) applyStimulus();
        done = 4'b0001;
        applyStimulus();
        done = 4'b0000;
        checkVal("tie_gnt", gnt, 4'b0000);
        checkVal("tie_err", timeout_err, 1'b0);
        applyStimulus();
        applyStimulus();

        // non-owner strobes are ignored
        doReset();
        req = 4'b1001;
        applyStimulus();
        checkVal("iso_gnt", gnt, 4'b0001);
        plot_in = 4'b1001;
        x_in = {9'd200, 9'd0, 9'd0, 9'd37};
        done = 4'b1000;
        repeat (4) begin
            applyStimulus();
            checkVal("iso_x_not_200", (x_out != 9'd200), 1);
            checkVal("iso_owner_kept", gnt, 4'b0001);
        end
        plot_in = 4'b1000;
        applyStimulus();
        checkVal("iso_plot_owner_only", plot, 1'b0);
        done = 4'b0001;
        applyStimulus();
        done = 4'b0000;

        // reset in the middle of a burst
        doReset();
        req = 4'b0100;
        applyStimulus();
        checkVal("rst_mid_gnt", gnt, 4'b0100);
        x_in = {4'($urandom), 32'($urandom)};
        y_in = $urandom; colour_in = 12'($urandom); plot_in = 4'b1111;
        applyStimulus();
        reset = 1'b0; req = 4'b1111;
        applyStimulus();
        checkVal("rst_mid_gnt_cleared", gnt, 4'b0000);
        checkVal("rst_mid_x_zero", x_out, 9'd0);
        reset = 1'b1;
        applyStimulus();
        checkVal("rst_first_gnt", gnt, 4'b0001);

        // random traffic
        repeat (400) begin
            reset     = ($urandom_range(0, 63) != 0);
            req       = 4'($urandom);
            done      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            plot_in   = 4'($urandom);
            x_in      = {4'($urandom), 32'($urandom)};
            y_in      = $urandom;
            colour_in = 12'($urandom);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL set the maximum number of OWN-state cycles before a grant is forcibly revoked (range 2..65535).
REQ-002 Clock: clk, rising-edge; reset: reset, synchronous, active-low.
REQ-003 Ports SHALL be exactly:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- req  in  4  per-requester access request (bit i = requester i: 0 player, 1 bullet, 2 aliens, 3 score)
- done  in  4  per-requester end-of-burst strobe
- plot_in  in  4  per-requester pixel write enable
- x_in  in  36  four 9-bit x coordinates, requester i at bits [9i+8:9i]
- y_in  in  32  four 8-bit y coordinates, requester i at bits [8i+7:8i]
- colour_in  in  12  four 3-bit colours, requester i at bits [3i+2:3i]
- gnt  out  4  one-hot grant, registered
- x_out  out  9  pixel x to VGA adapter, registered
- y_out  out  8  pixel y to VGA adapter, registered
- colour_out  out  3  pixel colour, registered
- plot  out  1  pixel write strobe, registered
- busy  out  1  high while any grant is held
- timeout_err  out  1  sticky forced-release flag

Function
REQ-004 The FSM SHALL have states IDLE, OWN and RELEASE, encoded in 2 bits; unused encoding SHALL go to IDLE.
REQ-005 IDLE: if any req bit is high, the next edge SHALL select one requester, set its gnt bit, enter OWN; otherwise stay in IDLE.
REQ-006 Selection SHALL be round-robin: search starts at index (last_owner+1) mod 4 and wraps; last_owner resets to 3, so requester 0 has priority after reset.
REQ-007 gnt SHALL be one-hot or zero at all times; at most one requester owns the port.
REQ-008 Grant latency: req sampled high in IDLE at edge n -> gnt high after edge n+1's output update (one cycle).
REQ-009 OWN: on each edge, x_out, y_out, colour_out, plot SHALL load the owner's x_in, y_in, colour_in, plot_in slices (one-cycle latency); non-owner inputs SHALL be ignored.
REQ-010 OWN: owner's done high at an edge -> gnt cleared, plot forced 0, last_owner updated, state RELEASE.
REQ-011 Owner dropping req without done SHALL NOT end ownership; only done or timeout ends it.
REQ-012 done or plot_in from a non-owner SHALL have no effect.
REQ-013 RELEASE SHALL last exactly one cycle with gnt=0, plot=0, then go to IDLE; consecutive grants are therefore separated by at least 2 idle cycles.
REQ-014 A 16-bit cycle counter SHALL clear on entry to OWN and increment each OWN cycle; when it reaches TIMEOUT-1 with no done, the next edge SHALL behave as REQ-010 and set timeout_err.
REQ-015 If done and timeout coincide, done SHALL take precedence; timeout_err SHALL NOT set.
REQ-016 timeout_err SHALL stay high until reset.
REQ-017 busy SHALL equal OR of gnt.
REQ-018 In IDLE and RELEASE, x_out/y_out/colour_out SHALL hold last values; plot SHALL be 0.

Reset
REQ-019 reset low at an edge SHALL force, regardless of state: state IDLE, gnt=0, plot=0, busy=0, x_out=0, y_out=0, colour_out=0, counter=0, last_owner=3, timeout_err=0.
REQ-020 Reset mid-burst SHALL drop the grant at that edge without entering RELEASE; first post-reset grant follows REQ-006.

Verification
REQ-021 Single request: after reset, req=0010 -> gnt=0010 one cycle later; x_in slice 1=100, plot_in[1]=1 -> x_out=100, plot=1 next cycle; done[1] -> gnt=0, then 1 RELEASE cycle.
REQ-022 Round-robin: req=1111 held, each owner pulses done after 3 cycles -> grant order 0,1,2,3,0.
REQ-023 Timeout: TIMEOUT=8, req[2] granted, done never asserted -> gnt[2] drops after 8 OWN cycles, timeout_err=1 and stays 1; next requester granted normally.
REQ-024 Done/timeout tie: done asserted on the cycle counter=TIMEOUT-1 -> release, timeout_err remains 0.
REQ-025 Isolation: owner 0 with plot_in=0001 while plot_in[3]=1, x_in slice 3=200 -> plot follows only bit 0, x_out never 200; done[3] ignored.
REQ-026 Reset mid-OWN: reset low while gnt=0100 -> next cycle gnt=0, plot=0, outputs zero; with req=1111 after release of reset, first grant=0001.
